mac_dot_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined multiply-accumulate unit; generalised successor of the 8-bit MAC.

---
 rtl/mac_dot_pipe_if.sv | 28 ++
 rtl/mac_dot_pipe.sv | 126 ++++++++++++
 tb/tb_mac_dot_pipe.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mac_dot_pipe_if.sv
// Sample-in / result-out bundle for the pipelined dot-product MAC.
// master drives samples and clear; slave is the MAC itself.
interface mac_dot_pipe_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W+8,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              last;
    logic              clear;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  count;
    logic [ACC_W-1:0]  result;
    logic              result_valid;
    logic              overflow;

    modport master (
        output in_valid, a, b, last, clear,
        input  acc, count, result, result_valid, overflow
    );

    modport slave (
        input  in_valid, a, b, last, clear,
        output acc, count, result, result_valid, overflow
    );
endinterface

// File: rtl/mac_dot_pipe.sv
// Two-stage multiply-accumulate: stage 1 registers a*b, stage 2 folds it into
// the running frame sum with optional saturation and a sticky overflow flag.
module mac_dot_pipe #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 2*DATA_W+8,
    parameter int CNT_W    = 16,
    parameter bit SIGNED   = 1'b0,
    parameter bit SATURATE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    mac_dot_pipe_if.slave bus
);
    localparam int PW = 2*DATA_W;

    logic [PW-1:0]    aExt_d;
    logic [PW-1:0]    bExt_d;
    logic [PW-1:0]    prod_d;
    logic [PW-1:0]    prod_q;
    logic             v1_q;
    logic             l1_q;

    logic [ACC_W-1:0] prodExt_d;
    logic [ACC_W-1:0] base_d;
    logic [ACC_W:0]   sumWide_d;
    logic [ACC_W-1:0] sumRaw_d;
    logic [ACC_W-1:0] satVal_d;
    logic             ovf_d;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] count_d;
    logic             overflow_d;

    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] count_q;
    logic [ACC_W-1:0] result_q;
    logic             resultValid_q;
    logic             overflow_q;
    logic             first_q;

    // Extending both operands to full product width lets one multiplier serve
    // both signednesses; the low PW bits of the product are exact either way.
    always_comb begin
        aExt_d = {{DATA_W{1'b0}}, bus.a};
        bExt_d = {{DATA_W{1'b0}}, bus.b};
        if (SIGNED) begin
            aExt_d = {{DATA_W{bus.a[DATA_W-1]}}, bus.a};
            bExt_d = {{DATA_W{bus.b[DATA_W-1]}}, bus.b};
        end
        prod_d = aExt_d * bExt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            v1_q   <= 1'b0;
            l1_q   <= 1'b0;
        end else if (bus.clear) begin
            prod_q <= '0;
            v1_q   <= 1'b0;
            l1_q   <= 1'b0;
        end else begin
            prod_q <= prod_d;
            v1_q   <= bus.in_valid;
            l1_q   <= bus.in_valid & bus.last;
        end
    end

    // A fresh frame starts from zero rather than the held previous sum.
    always_comb begin
        prodExt_d = ACC_W'(prod_q);
        if (SIGNED) begin
            prodExt_d = ACC_W'($signed(prod_q));
        end
        base_d    = first_q ? '0 : acc_q;
        sumWide_d = {1'b0, base_d} + {1'b0, prodExt_d};
        sumRaw_d  = sumWide_d[ACC_W-1:0];
        ovf_d     = sumWide_d[ACC_W];
        satVal_d  = '1;
        if (SIGNED) begin
            ovf_d    = (base_d[ACC_W-1] == prodExt_d[ACC_W-1]) &&
                       (sumRaw_d[ACC_W-1] != base_d[ACC_W-1]);
            satVal_d = base_d[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
        end
        acc_d      = (ovf_d && SATURATE) ? satVal_d : sumRaw_d;
        count_d    = first_q ? CNT_W'(1) : count_q + CNT_W'(1);
        overflow_d = (first_q ? 1'b0 : overflow_q) | ovf_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q         <= '0;
            count_q       <= '0;
            result_q      <= '0;
            resultValid_q <= 1'b0;
            overflow_q    <= 1'b0;
            first_q       <= 1'b1;
        end else if (bus.clear) begin
            acc_q         <= '0;
            count_q       <= '0;
            resultValid_q <= 1'b0;
            overflow_q    <= 1'b0;
            first_q       <= 1'b1;
        end else begin
            resultValid_q <= 1'b0;
            if (v1_q) begin
                acc_q      <= acc_d;
                count_q    <= count_d;
                overflow_q <= overflow_d;
                if (l1_q) begin
                    result_q      <= acc_d;
                    resultValid_q <= 1'b1;
                    first_q       <= 1'b1;
                end else begin
                    first_q <= 1'b0;
                end
            end
        end
    end

    assign bus.acc          = acc_q;
    assign bus.count        = count_q;
    assign bus.result       = result_q;
    assign bus.result_valid = resultValid_q;
    assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_mac_dot_pipe.sv
// Directed bench for mac_dot_pipe: default 24-bit accumulator plus three
// 16-bit variants (unsigned saturate, unsigned wrap, signed saturate).
module tb_mac_dot_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   testsRun = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    mac_dot_pipe_if #(.DATA_W(8), .ACC_W(24), .CNT_W(16)) ifD ();
    mac_dot_pipe_if #(.DATA_W(8), .ACC_W(16), .CNT_W(16)) ifS ();
    mac_dot_pipe_if #(.DATA_W(8), .ACC_W(16), .CNT_W(16)) ifW ();
    mac_dot_pipe_if #(.DATA_W(8), .ACC_W(16), .CNT_W(16)) ifG ();

    mac_dot_pipe #(.DATA_W(8), .ACC_W(24), .CNT_W(16), .SIGNED(1'b0), .SATURATE(1'b1))
        dutD (.clk(clk), .rst_n(rst_n), .bus(ifD));
    mac_dot_pipe #(.DATA_W(8), .ACC_W(16), .CNT_W(16), .SIGNED(1'b0), .SATURATE(1'b1))
        dutS (.clk(clk), .rst_n(rst_n), .bus(ifS));
    mac_dot_pipe #(.DATA_W(8), .ACC_W(16), .CNT_W(16), .SIGNED(1'b0), .SATURATE(1'b0))
        dutW (.clk(clk), .rst_n(rst_n), .bus(ifW));
    mac_dot_pipe #(.DATA_W(8), .ACC_W(16), .CNT_W(16), .SIGNED(1'b1), .SATURATE(1'b1))
        dutG (.clk(clk), .rst_n(rst_n), .bus(ifG));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drvD(input logic [7:0] a, input logic [7:0] b, input logic v, input logic l);
        ifD.a = a; ifD.b = b; ifD.in_valid = v; ifD.last = l;
    endtask

    task automatic drvU(input logic [7:0] a, input logic [7:0] b, input logic v, input logic l);
        ifS.a = a; ifS.b = b; ifS.in_valid = v; ifS.last = l;
        ifW.a = a; ifW.b = b; ifW.in_valid = v; ifW.last = l;
    endtask

    task automatic drvG(input logic [7:0] a, input logic [7:0] b, input logic v, input logic l);
        ifG.a = a; ifG.b = b; ifG.in_valid = v; ifG.last = l;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        testsRun++; if (ifD.acc !== 24'd0) begin testsFailed++; $display("[TB] FAIL reset_acc got %0d want 0", ifD.acc); end
        testsRun++; if (ifD.count !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_count got %0d want 0", ifD.count); end
        testsRun++; if (ifD.result !== 24'd0) begin testsFailed++; $display("[TB] FAIL reset_result got %0d want 0", ifD.result); end
        testsRun++; if (ifD.result_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rv got %b want 0", ifD.result_valid); end
        testsRun++; if (ifD.overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ovf got %b want 0", ifD.overflow); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_accumulate();
        drvD(8'd2, 8'd4, 1'b1, 1'b0); tick();
        drvD(8'd4, 8'd4, 1'b1, 1'b0); tick();
        testsRun++; if (ifD.acc !== 24'd8) begin testsFailed++; $display("[TB] FAIL acc_t1 got %0d want 8", ifD.acc); end
        testsRun++; if (ifD.count !== 16'd1) begin testsFailed++; $display("[TB] FAIL count_t1 got %0d want 1", ifD.count); end
        drvD(8'd3, 8'd5, 1'b1, 1'b1); tick();
        testsRun++; if (ifD.acc !== 24'd24) begin testsFailed++; $display("[TB] FAIL acc_t2 got %0d want 24", ifD.acc); end
        testsRun++; if (ifD.result_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rv_early got %b want 0", ifD.result_valid); end
        drvD(8'd0, 8'd0, 1'b0, 1'b0); tick();
        testsRun++; if (ifD.acc !== 24'd39) begin testsFailed++; $display("[TB] FAIL acc_t3 got %0d want 39", ifD.acc); end
        testsRun++; if (ifD.count !== 16'd3) begin testsFailed++; $display("[TB] FAIL count_t3 got %0d want 3", ifD.count); end
        testsRun++; if (ifD.result !== 24'd39) begin testsFailed++; $display("[TB] FAIL result_f1 got %0d want 39", ifD.result); end
        testsRun++; if (ifD.result_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL rv_pulse got %b want 1", ifD.result_valid); end
        tick();
        testsRun++; if (ifD.result_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rv_drop got %b want 0", ifD.result_valid); end
        testsRun++; if (ifD.result !== 24'd39) begin testsFailed++; $display("[TB] FAIL result_hold got %0d want 39", ifD.result); end
        testsRun++; if (ifD.acc !== 24'd39) begin testsFailed++; $display("[TB] FAIL acc_hold got %0d want 39", ifD.acc); end
    endtask

    task automatic test_back_to_back();
        drvD(8'd2, 8'd4, 1'b1, 1'b0); tick();
        drvD(8'd4, 8'd4, 1'b1, 1'b0); tick();
        drvD(8'd3, 8'd5, 1'b1, 1'b1); tick();
        drvD(8'd1, 8'd1, 1'b1, 1'b1); tick();
        testsRun++; if (ifD.result !== 24'd39) begin testsFailed++; $display("[TB] FAIL b2b_result1 got %0d want 39", ifD.result); end
        testsRun++; if (ifD.result_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_rv1 got %b want 1", ifD.result_valid); end
        drvD(8'd0, 8'd0, 1'b0, 1'b0); tick();
        testsRun++; if (ifD.acc !== 24'd1) begin testsFailed++; $display("[TB] FAIL b2b_acc got %0d want 1", ifD.acc); end
        testsRun++; if (ifD.count !== 16'd1) begin testsFailed++; $display("[TB] FAIL b2b_count got %0d want 1", ifD.count); end
        testsRun++; if (ifD.result !== 24'd1) begin testsFailed++; $display("[TB] FAIL b2b_result2 got %0d want 1", ifD.result); end
        testsRun++; if (ifD.result_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_rv2 got %b want 1", ifD.result_valid); end
        tick();
        testsRun++; if (ifD.result_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_rv_drop got %b want 0", ifD.result_valid); end
    endtask

    task automatic test_clear();
        drvD(8'd1, 8'd2, 1'b1, 1'b0); tick();
        drvD(8'd3, 8'd4, 1'b1, 1'b0); tick();
        drvD(8'd5, 8'd6, 1'b1, 1'b0); tick();
        testsRun++; if (ifD.acc !== 24'd14) begin testsFailed++; $display("[TB] FAIL clr_pre_acc got %0d want 14", ifD.acc); end
        drvD(8'd7, 8'd7, 1'b1, 1'b0); ifD.clear = 1'b1; tick();
        ifD.clear = 1'b0;
        testsRun++; if (ifD.acc !== 24'd0) begin testsFailed++; $display("[TB] FAIL clr_acc got %0d want 0", ifD.acc); end
        testsRun++; if (ifD.count !== 16'd0) begin testsFailed++; $display("[TB] FAIL clr_count got %0d want 0", ifD.count); end
        testsRun++; if (ifD.overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL clr_ovf got %b want 0", ifD.overflow); end
        testsRun++; if (ifD.result !== 24'd1) begin testsFailed++; $display("[TB] FAIL clr_result got %0d want 1", ifD.result); end
        drvD(8'd0, 8'd0, 1'b0, 1'b0); tick();
        testsRun++; if (ifD.acc !== 24'd0) begin testsFailed++; $display("[TB] FAIL clr_dropped_acc got %0d want 0", ifD.acc); end
        testsRun++; if (ifD.result_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL clr_rv got %b want 0", ifD.result_valid); end
        drvD(8'd1, 8'd2, 1'b1, 1'b1); tick();
        drvD(8'd0, 8'd0, 1'b0, 1'b0); tick();
        testsRun++; if (ifD.result !== 24'd2) begin testsFailed++; $display("[TB] FAIL clr_next_result got %0d want 2", ifD.result); end
        testsRun++; if (ifD.count !== 16'd1) begin testsFailed++; $display("[TB] FAIL clr_next_count got %0d want 1", ifD.count); end
    endtask

    task automatic test_unsigned_overflow();
        drvU(8'd255, 8'd255, 1'b1, 1'b0); tick();
        drvU(8'd255, 8'd255, 1'b1, 1'b1); tick();
        testsRun++; if (ifS.acc !== 16'd65025) begin testsFailed++; $display("[TB] FAIL sat_t1 got %0d want 65025", ifS.acc); end
        testsRun++; if (ifS.overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL sat_ovf_t1 got %b want 0", ifS.overflow); end
        drvU(8'd0, 8'd0, 1'b0, 1'b0); tick();
        testsRun++; if (ifS.acc !== 16'd65535) begin testsFailed++; $display("[TB] FAIL sat_acc got %0d want 65535", ifS.acc); end
        testsRun++; if (ifS.overflow !== 1'b1) begin testsFailed++; $display("[TB] FAIL sat_ovf got %b want 1", ifS.overflow); end
        testsRun++; if (ifS.result !== 16'd65535) begin testsFailed++; $display("[TB] FAIL sat_result got %0d want 65535", ifS.result); end
        testsRun++; if (ifW.acc !== 16'd64514) begin testsFailed++; $display("[TB] FAIL wrap_acc got %0d want 64514", ifW.acc); end
        testsRun++; if (ifW.overflow !== 1'b1) begin testsFailed++; $display("[TB] FAIL wrap_ovf got %b want 1", ifW.overflow); end
        drvU(8'd1, 8'd1, 1'b1, 1'b1); tick();
        drvU(8'd0, 8'd0, 1'b0, 1'b0); tick();
        testsRun++; if (ifS.acc !== 16'd1) begin testsFailed++; $display("[TB] FAIL sat_new_acc got %0d want 1", ifS.acc); end
        testsRun++; if (ifS.overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL sat_new_ovf got %b want 0", ifS.overflow); end
    endtask

    task automatic test_signed_saturate();
        drvG(8'h80, 8'h7F, 1'b1, 1'b0); tick();
        drvG(8'h80, 8'h7F, 1'b1, 1'b0); tick();
        testsRun++; if (ifG.acc !== 16'hC080) begin testsFailed++; $display("[TB] FAIL sgn_t1 got %h want c080", ifG.acc); end
        drvG(8'h80, 8'h7F, 1'b1, 1'b0); tick();
        testsRun++; if (ifG.acc !== 16'h8100) begin testsFailed++; $display("[TB] FAIL sgn_t2 got %h want 8100", ifG.acc); end
        testsRun++; if (ifG.overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL sgn_ovf_t2 got %b want 0", ifG.overflow); end
        drvG(8'h01, 8'h01, 1'b1, 1'b1); tick();
        testsRun++; if (ifG.acc !== 16'h8000) begin testsFailed++; $display("[TB] FAIL sgn_clamp got %h want 8000", ifG.acc); end
        testsRun++; if (ifG.overflow !== 1'b1) begin testsFailed++; $display("[TB] FAIL sgn_ovf got %b want 1", ifG.overflow); end
        drvG(8'h00, 8'h00, 1'b0, 1'b0); tick();
        testsRun++; if (ifG.result !== 16'h8001) begin testsFailed++; $display("[TB] FAIL sgn_result got %h want 8001", ifG.result); end
        testsRun++; if (ifG.overflow !== 1'b1) begin testsFailed++; $display("[TB] FAIL sgn_ovf_sticky got %b want 1", ifG.overflow); end
        testsRun++; if (ifG.count !== 16'd4) begin testsFailed++; $display("[TB] FAIL sgn_count got %0d want 4", ifG.count); end
    endtask

    task automatic test_async_reset();
        drvD(8'd3, 8'd3, 1'b1, 1'b0); tick();
        drvD(8'd0, 8'd0, 1'b0, 1'b0); tick();
        testsRun++; if (ifD.acc !== 24'd9) begin testsFailed++; $display("[TB] FAIL arst_pre_acc got %0d want 9", ifD.acc); end
        #3;
        rst_n = 1'b0;
        #1;
        testsRun++; if (ifD.acc !== 24'd0) begin testsFailed++; $display("[TB] FAIL arst_acc got %0d want 0", ifD.acc); end
        testsRun++; if (ifD.count !== 16'd0) begin testsFailed++; $display("[TB] FAIL arst_count got %0d want 0", ifD.count); end
        testsRun++; if (ifD.result !== 24'd0) begin testsFailed++; $display("[TB] FAIL arst_result got %0d want 0", ifD.result); end
        testsRun++; if (ifG.overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL arst_ovf got %b want 0", ifG.overflow); end
        tick();
        rst_n = 1'b1;
        tick();
        drvD(8'd3, 8'd3, 1'b1, 1'b1); tick();
        drvD(8'd0, 8'd0, 1'b0, 1'b0); tick();
        testsRun++; if (ifD.result !== 24'd9) begin testsFailed++; $display("[TB] FAIL arst_next_result got %0d want 9", ifD.result); end
        testsRun++; if (ifD.count !== 16'd1) begin testsFailed++; $display("[TB] FAIL arst_next_count got %0d want 1", ifD.count); end
    endtask

    initial begin
        drvD(8'd0, 8'd0, 1'b0, 1'b0); ifD.clear = 1'b0;
        drvU(8'd0, 8'd0, 1'b0, 1'b0); ifS.clear = 1'b0; ifW.clear = 1'b0;
        drvG(8'd0, 8'd0, 1'b0, 1'b0); ifG.clear = 1'b0;
        test_reset();
        test_accumulate();
        test_back_to_back();
        test_clear();
        test_unsigned_overflow();
        test_signed_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
